maze_move_sched: RTL and testbench

MAZE_MOVE_SCHED -- requirements
Module: maze_move_sched

---
 rtl/maze_pkg.sv | 14 +
 rtl/maze_move_sched_if.sv | 9 +
 rtl/move_fifo.sv | 47 ++++
 rtl/maze_move_sched.sv | 111 +++++++++++
 tb/tb_maze_move_sched.sv | 200 ++++++++++++++++++++
 5 files changed

// File: rtl/maze_pkg.sv
// maze_pkg: shared tile codes, key codes, FSM states and default maze size for the maze mover
package maze_pkg;
    localparam int DEF_ROWS = 12;
    localparam int DEF_COLS = 16;
    localparam logic [1:0] PATH = 2'd0;
    localparam logic [1:0] WALL = 2'd1;
    localparam logic [1:0] GOAL = 2'd2;
    localparam logic [7:0] KEY_LEFT  = 8'h1C;
    localparam logic [7:0] KEY_RIGHT = 8'h23;
    localparam logic [7:0] KEY_DOWN  = 8'h1B;
    localparam logic [7:0] KEY_UP    = 8'h1D;
    typedef enum logic [1:0] {IDLE, REQ, WAIT, WIN} state_t;
    typedef enum logic [1:0] {D_LEFT, D_RIGHT, D_DOWN, D_UP} dir_t;
endpackage

// File: rtl/maze_move_sched_if.sv
// maze_move_sched_if: map tile read bus; data returns one cycle after the request
interface maze_move_sched_if;
    logic       map_req_o;
    logic [3:0] map_row_o;
    logic [3:0] map_col_o;
    logic [1:0] map_data_i;
    modport master (output map_req_o, map_row_o, map_col_o, input map_data_i);
    modport slave (input map_req_o, map_row_o, map_col_o, output map_data_i);
endinterface

// File: rtl/move_fifo.sv
// move_fifo: queue of 2-bit move directions; a push while full is taken only alongside a pop
module move_fifo
    import maze_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic CLKOUT,
    input  logic aclr_i,
    input  logic flush,
    input  logic push,
    input  logic pop,
    input  dir_t din,
    output dir_t dout,
    output logic full,
    output logic empty
);
    localparam int AW = $clog2(DEPTH);
    dir_t mem [DEPTH];
    logic [AW-1:0] rd, wr;
    logic [AW:0] cnt;
    logic wr_en, rd_en;
    assign full  = cnt == (AW+1)'(DEPTH);
    assign empty = cnt == '0;
    assign wr_en = push && (!full || pop);
    assign rd_en = pop && !empty;
    assign dout  = mem[rd];
    // pointers and occupancy; flush empties the queue in one cycle
    always_ff @(posedge CLKOUT or posedge aclr_i) begin
        if (aclr_i) begin
            rd  <= '0;
            wr  <= '0;
            cnt <= '0;
        end else if (flush) begin
            rd  <= '0;
            wr  <= '0;
            cnt <= '0;
        end else begin
            if (wr_en) wr <= wr + 1'b1;
            if (rd_en) rd <= rd + 1'b1;
            cnt <= cnt + (AW+1)'(wr_en) - (AW+1)'(rd_en);
        end
    end
    // storage; the slot being popped is read before it can be overwritten
    always_ff @(posedge CLKOUT) begin
        if (wr_en && !flush) mem[wr] <= din;
    end
endmodule

// File: rtl/maze_move_sched.sv
// maze_move_sched: queues key moves and walks the ball through the maze; STEP_COUNTER_EN builds the step counter
module maze_move_sched
    import maze_pkg::*;
#(
    parameter int ROWS       = DEF_ROWS,
    parameter int COLS       = DEF_COLS,
    parameter int FIFO_DEPTH = 4,
    parameter int WIN_HOLD   = 1024
) (
    input  logic              CLKOUT,
    input  logic              aclr_i,
    input  logic              kbstrobe_i,
    input  logic [7:0]        kbcode_i,
    maze_move_sched_if.master map,
    output logic [3:0]        ball_row_o,
    output logic [3:0]        ball_col_o,
    output logic              busy_o,
    output logic              bump_o,
    output logic              drop_o,
    output logic              win_o,
    output logic [9:0]        step_cnt_o
);
    localparam int WW = $clog2(WIN_HOLD) + 1;
    state_t state, nxt;
    dir_t key_dir, head;
    logic key_ok, push, pop, full, empty, oob, move, win_done, bump_nxt;
    logic [3:0] tgt_row, tgt_col, nxt_row, nxt_col;
    logic [WW-1:0] win_cnt;
    assign key_ok  = kbcode_i inside {KEY_LEFT, KEY_RIGHT, KEY_DOWN, KEY_UP};
    assign key_dir = kbcode_i == KEY_LEFT ? D_LEFT : kbcode_i == KEY_RIGHT ? D_RIGHT :
                     kbcode_i == KEY_DOWN ? D_DOWN : D_UP;
    assign push = kbstrobe_i && key_ok && state != WIN;
    assign pop  = state == IDLE && !empty;
    move_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .CLKOUT(CLKOUT), .aclr_i(aclr_i), .flush(state == WIN), .push(push), .pop(pop),
        .din(key_dir), .dout(head), .full(full), .empty(empty)
    );
    assign oob = (head == D_LEFT  && ball_col_o == '0) ||
                 (head == D_RIGHT && ball_col_o == 4'(COLS-1)) ||
                 (head == D_DOWN  && ball_row_o == 4'(ROWS-1)) ||
                 (head == D_UP    && ball_row_o == '0);
    assign nxt_row = head == D_DOWN ? ball_row_o + 4'd1 : head == D_UP ? ball_row_o - 4'd1 : ball_row_o;
    assign nxt_col = head == D_RIGHT ? ball_col_o + 4'd1 : head == D_LEFT ? ball_col_o - 4'd1 : ball_col_o;
    assign move     = state == WAIT && (map.map_data_i == PATH || map.map_data_i == GOAL);
    assign win_done = state == WIN && win_cnt == WW'(WIN_HOLD-1);
    assign map.map_req_o = state == REQ;
    assign map.map_row_o = tgt_row;
    assign map.map_col_o = tgt_col;
    assign win_o  = state == WIN;
    assign busy_o = state != IDLE || !empty;
    // state register
    always_ff @(posedge CLKOUT or posedge aclr_i) begin
        if (aclr_i) state <= IDLE;
        else        state <= nxt;
    end
    // next state and rejected-move detection
    always_comb begin
        nxt      = state;
        bump_nxt = 1'b0;
        case (state)
            IDLE: begin
                nxt      = pop && !oob ? REQ : IDLE;
                bump_nxt = pop && oob;
            end
            REQ:  nxt = WAIT;
            WAIT: begin
                nxt      = map.map_data_i == GOAL ? WIN : IDLE;
                bump_nxt = !move;
            end
            WIN:  nxt = win_done ? IDLE : WIN;
            default: nxt = IDLE;
        endcase
    end
    // target latch, ball position, win timer and event pulses
    always_ff @(posedge CLKOUT or posedge aclr_i) begin
        if (aclr_i) begin
            tgt_row    <= '0;
            tgt_col    <= '0;
            ball_row_o <= '0;
            ball_col_o <= '0;
            win_cnt    <= '0;
            bump_o     <= 1'b0;
            drop_o     <= 1'b0;
        end else begin
            bump_o  <= bump_nxt;
            drop_o  <= push && full && !pop;
            win_cnt <= state == WIN && !win_done ? win_cnt + 1'b1 : '0;
            if (pop && !oob) begin
                tgt_row <= nxt_row;
                tgt_col <= nxt_col;
            end
            if (move) begin
                ball_row_o <= tgt_row;
                ball_col_o <= tgt_col;
            end else if (win_done) begin
                ball_row_o <= '0;
                ball_col_o <= '0;
            end
        end
    end
`ifdef STEP_COUNTER_EN
    // saturating count of successful moves, cleared when a win completes
    always_ff @(posedge CLKOUT or posedge aclr_i) begin
        if (aclr_i)                          step_cnt_o <= '0;
        else if (win_done)                   step_cnt_o <= '0;
        else if (move && step_cnt_o != '1)   step_cnt_o <= step_cnt_o + 10'd1;
    end
`else
    assign step_cnt_o = '0;
`endif
endmodule

// File: tb/tb_maze_move_sched.sv
// tb_maze_move_sched: directed vectors and multi-cycle sequences for maze_move_sched
module tb_maze_move_sched;
    import maze_pkg::*;
    logic CLKOUT = 1'b0;
    logic aclr_i = 1'b1;
    logic kbstrobe_i = 1'b0;
    logic [7:0] kbcode_i = 8'h00;
    logic [3:0] ball_row_o, ball_col_o;
    logic busy_o, bump_o, drop_o, win_o;
    logic [9:0] step_cnt_o;
    maze_move_sched_if bus ();
    maze_move_sched dut (
        .CLKOUT(CLKOUT), .aclr_i(aclr_i), .kbstrobe_i(kbstrobe_i), .kbcode_i(kbcode_i),
        .map(bus.master), .ball_row_o(ball_row_o), .ball_col_o(ball_col_o), .busy_o(busy_o),
        .bump_o(bump_o), .drop_o(drop_o), .win_o(win_o), .step_cnt_o(step_cnt_o)
    );
    always #5 CLKOUT = ~CLKOUT;

    int total = 0;
    int bad = 0;
    int n_bump = 0, n_drop = 0, n_req = 0;
    int last_row = 0, last_col = 0;

    function automatic logic [1:0] tile(input logic [3:0] r, input logic [3:0] c);
        return (r == 0 && c == 1) ? WALL : (r == 11 && c == 15) ? GOAL : PATH;
    endfunction

    // map memory model: answers one cycle after a request, junk otherwise
    always @(posedge CLKOUT) bus.map_data_i <= bus.map_req_o ? tile(bus.map_row_o, bus.map_col_o) : 2'd3;

    always @(posedge CLKOUT) begin
        if (bump_o) n_bump++;
        if (drop_o) n_drop++;
        if (bus.map_req_o) begin
            n_req++;
            last_row = int'(bus.map_row_o);
            last_col = int'(bus.map_col_o);
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic clr_mon();
        n_bump = 0; n_drop = 0; n_req = 0;
    endtask

    task automatic do_reset();
        @(negedge CLKOUT) aclr_i = 1'b1;
        @(negedge CLKOUT) aclr_i = 1'b0;
        clr_mon();
    endtask

    task automatic strobe(input logic [7:0] code);
        @(negedge CLKOUT) begin kbstrobe_i = 1'b1; kbcode_i = code; end
        @(negedge CLKOUT) kbstrobe_i = 1'b0;
    endtask

    task automatic move(input logic [7:0] code);
        strobe(code);
        repeat (4) @(negedge CLKOUT);
    endtask

    function automatic int stp(input int n);
`ifdef STEP_COUNTER_EN
        return n;
`else
        return 0 * n;
`endif
    endfunction

    typedef struct {
        logic [7:0] code;
        int row, col, bumps, reqs, arow, acol, steps;
    } vec_t;
    vec_t vt [10];

    initial begin
        vt[0] = '{8'h23, 0, 0, 1, 1, 0, 1, 0};
        vt[1] = '{8'h1D, 0, 0, 1, 0, 0, 0, 0};
        vt[2] = '{8'h1C, 0, 0, 1, 0, 0, 0, 0};
        vt[3] = '{8'h55, 0, 0, 0, 0, 0, 0, 0};
        vt[4] = '{8'h1B, 1, 0, 0, 1, 1, 0, 1};
        vt[5] = '{8'h23, 1, 1, 0, 1, 1, 1, 2};
        vt[6] = '{8'h1D, 1, 1, 1, 1, 0, 1, 2};
        vt[7] = '{8'h1C, 1, 0, 0, 1, 1, 0, 3};
        vt[8] = '{8'h1C, 1, 0, 1, 0, 0, 0, 3};
        vt[9] = '{8'h1D, 0, 0, 0, 1, 0, 0, 4};

        #1;
        chk("rst_row", int'(ball_row_o), 0);
        chk("rst_col", int'(ball_col_o), 0);
        chk("rst_busy", int'(busy_o), 0);
        chk("rst_req", int'(bus.map_req_o), 0);
        chk("rst_win", int'(win_o), 0);
        chk("rst_step", int'(step_cnt_o), 0);
        do_reset();

        for (int i = 0; i < 10; i++) begin
            clr_mon();
            strobe(vt[i].code);
            repeat (5) @(negedge CLKOUT);
            chk($sformatf("v%0d_row", i), int'(ball_row_o), vt[i].row);
            chk($sformatf("v%0d_col", i), int'(ball_col_o), vt[i].col);
            chk($sformatf("v%0d_bump", i), n_bump, vt[i].bumps);
            chk($sformatf("v%0d_req", i), n_req, vt[i].reqs);
            chk($sformatf("v%0d_drop", i), n_drop, 0);
            chk($sformatf("v%0d_step", i), int'(step_cnt_o), stp(vt[i].steps));
            if (vt[i].reqs != 0) begin
                chk($sformatf("v%0d_arow", i), last_row, vt[i].arow);
                chk($sformatf("v%0d_acol", i), last_col, vt[i].acol);
            end
        end

        do_reset();
        strobe(8'h1B);
        repeat (2) @(negedge CLKOUT);
        chk("lat_e2_row", int'(ball_row_o), 0);
        @(negedge CLKOUT);
        chk("lat_e3_row", int'(ball_row_o), 1);
        chk("lat_e3_col", int'(ball_col_o), 0);
        chk("lat_step", int'(step_cnt_o), stp(1));

        do_reset();
        for (int i = 0; i < 9; i++) begin
            @(negedge CLKOUT) begin kbstrobe_i = 1'b1; kbcode_i = (i % 2 == 0) ? KEY_DOWN : KEY_RIGHT; end
        end
        @(negedge CLKOUT) kbstrobe_i = 1'b0;
        chk("q_busy", int'(busy_o), 1);
        repeat (30) @(negedge CLKOUT);
        chk("q_drop", n_drop, 2);
        chk("q_req", n_req, 7);
        chk("q_row", int'(ball_row_o), 3);
        chk("q_col", int'(ball_col_o), 4);
        chk("q_step", int'(step_cnt_o), stp(7));
        chk("q_idle", int'(busy_o), 0);

        do_reset();
        repeat (10) move(KEY_DOWN);
        repeat (15) move(KEY_RIGHT);
        chk("w_pre_row", int'(ball_row_o), 10);
        chk("w_pre_col", int'(ball_col_o), 15);
        clr_mon();
        strobe(KEY_DOWN);
        repeat (3) @(negedge CLKOUT);
        chk("w_row", int'(ball_row_o), 11);
        chk("w_col", int'(ball_col_o), 15);
        chk("w_step", int'(step_cnt_o), stp(26));
        begin
            int n = 0;
            while (win_o && n < 2000) begin
                kbstrobe_i = n < 6;
                kbcode_i = KEY_DOWN;
                n++;
                @(negedge CLKOUT);
            end
            kbstrobe_i = 1'b0;
            chk("w_len", n, 1024);
        end
        chk("w_drop", n_drop, 0);
        chk("w_end_row", int'(ball_row_o), 0);
        chk("w_end_col", int'(ball_col_o), 0);
        chk("w_end_step", int'(step_cnt_o), 0);
        repeat (5) @(negedge CLKOUT);
        chk("w_flush_req", n_req, 1);
        chk("w_flush_busy", int'(busy_o), 0);
        chk("w_flush_row", int'(ball_row_o), 0);

        do_reset();
        move(KEY_DOWN);
        strobe(KEY_RIGHT);
        @(negedge CLKOUT);
        chk("a_in_req", int'(bus.map_req_o), 1);
        @(negedge CLKOUT);
        aclr_i = 1'b1;
        #1;
        chk("a_row", int'(ball_row_o), 0);
        chk("a_col", int'(ball_col_o), 0);
        chk("a_busy", int'(busy_o), 0);
        chk("a_req", int'(bus.map_req_o), 0);
        chk("a_bump", int'(bump_o), 0);
        chk("a_drop", int'(drop_o), 0);
        chk("a_win", int'(win_o), 0);
        chk("a_step", int'(step_cnt_o), 0);
        @(negedge CLKOUT) aclr_i = 1'b0;
        clr_mon();
        repeat (5) @(negedge CLKOUT);
        chk("a_post_row", int'(ball_row_o), 0);
        chk("a_post_col", int'(ball_col_o), 0);
        chk("a_post_req", n_req, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
